// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory read-response demultiplexer.
// The tracking entry is stored at a fixed maximum width; narrower requester
// IDs and burst lengths are zero-extended into it.
package mem_resp_pkg;

  // Destination indices on the return path
  localparam int DST_ICACHE = 0;
  localparam int DST_DCACHE = 1;

  // Default configuration
  localparam int DEF_WIDTH = 32;
  localparam int DEF_N_DST = 2;
  localparam int DEF_ID_W  = 1;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_DEPTH = 4;

  // Storage widths of one tracking entry (upper bounds for ID_W / LEN_W)
  localparam int MAX_ID_W  = 4;
  localparam int MAX_LEN_W = 8;

  typedef struct packed {
    logic [MAX_ID_W-1:0]  id;
    logic [MAX_LEN_W-1:0] len;
  } resp_entry_t;

endpackage

// File: rtl/mem_resp_demux_if.sv
// Request-tracking and response-routing signal bundle of mem_resp_demux.
// master: arbiter / memory / destinations side; slave: the demux itself.
interface mem_resp_demux_if #(
  parameter int WIDTH = 32,
  parameter int N_DST = 2,
  parameter int ID_W  = 1,
  parameter int LEN_W = 4
) ();

  logic             req_fire;
  logic [ID_W-1:0]  req_id;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_rready;
  logic [N_DST-1:0] dst_valid;
  logic [WIDTH-1:0] dst_data;
  logic             dst_last;
  logic [N_DST-1:0] dst_ready;
  logic             id_err;

  modport master (
    output req_fire, req_id, req_len, mem_rvalid, mem_rdata, dst_ready,
    input  req_ready, mem_rready, dst_valid, dst_data, dst_last, id_err
  );

  modport slave (
    input  req_fire, req_id, req_len, mem_rvalid, mem_rdata, dst_ready,
    output req_ready, mem_rready, dst_valid, dst_data, dst_last, id_err
  );

endinterface

// File: rtl/mem_resp_demux_chk.sv
// Protocol checker: the arbiter must never fire a request while the
// tracking FIFO is full (such a request would be dropped).
module mem_resp_demux_chk (
  input logic clk,
  input logic rst,
  input logic req_fire,
  input logic req_ready
);

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(req_fire && !req_ready)
  );

endmodule

// File: rtl/resp_id_fifo.sv
// Generic synchronous FIFO with full/empty flags. Pointers carry one extra
// wrap bit so that full and empty are distinguishable; DEPTH must be a power
// of 2. Push while full and pop while empty are ignored.
module resp_id_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;

  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign rdata = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer advance and entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

endmodule

// File: rtl/mem_resp_demux.sv
// Read-response demultiplexer: tracks outstanding memory requests in order
// and steers each response burst back to the requester that issued it.
// Optional build macro MEM_RESP_DEMUX_OUTREG_EN: destination outputs come
// from a 2-entry skid buffer (1 cycle latency, full throughput). Without it
// the destination outputs are a zero-latency pass-through of the FIFO head.
module mem_resp_demux
  import mem_resp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_DST = DEF_N_DST,
  parameter int ID_W  = DEF_ID_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  mem_resp_demux_if.slave   bus
);

  resp_entry_t      wr_entry_s;
  resp_entry_t      head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             hid_ok_s;
  logic             sel_ready_s;
  logic             at_last_s;
  logic             accept_s;
  logic             pop_s;
  logic [LEN_W-1:0] beat_cnt_r;
  logic             id_err_r;

  assign wr_entry_s = '{id: MAX_ID_W'(bus.req_id), len: MAX_LEN_W'(bus.req_len)};

  resp_id_fifo #(
    .W     ($bits(resp_entry_t)),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_fire),
    .pop   (pop_s),
    .wdata (wr_entry_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  mem_resp_demux_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_fire  (bus.req_fire),
    .req_ready (bus.req_ready)
  );

  // A slot frees only after the pop edge, so a same-cycle pop never admits a push
  assign bus.req_ready = !fifo_full_s;
  assign bus.id_err    = id_err_r;

  // Decode the FIFO head: ID range check, selected ready, last-beat detect
  always_comb begin
    hid_ok_s    = (32'(head_s.id) < N_DST);
    sel_ready_s = 1'b0;
    for (int i = 0; i < N_DST; i++) begin
      sel_ready_s = sel_ready_s | (bus.dst_ready[i] & (head_s.id == MAX_ID_W'(i)));
    end
    at_last_s   = !fifo_empty_s && (MAX_LEN_W'(beat_cnt_r) == head_s.len);
  end

  assign accept_s = bus.mem_rvalid && bus.mem_rready;
  assign pop_s    = accept_s && at_last_s;

  // Beat counter within the current burst; restarts after the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r <= '0;
    end else if (accept_s) begin
      beat_cnt_r <= at_last_s ? '0 : beat_cnt_r + LEN_W'(1);
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Sticky flag for any beat drained under an out-of-range requester ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_err_r <= 1'b0;
    end else if (accept_s && !hid_ok_s) begin
      id_err_r <= 1'b1;
    end else begin
      id_err_r <= id_err_r;
    end
  end

`ifdef MEM_RESP_DEMUX_OUTREG_EN

  logic [N_DST-1:0] skid_dst_r  [2];
  logic [WIDTH-1:0] skid_data_r [2];
  logic             skid_last_r [2];
  logic             skid_rd_r;
  logic [1:0]       skid_cnt_r;
  logic             skid_wr_s;
  logic             skid_push_s;
  logic             skid_pop_s;
  logic [N_DST-1:0] head_onehot_s;

  // Skid-side control: one-hot of the head ID, push/pop strobes, write slot
  always_comb begin
    head_onehot_s = '0;
    for (int i = 0; i < N_DST; i++) begin
      head_onehot_s[i] = (head_s.id == MAX_ID_W'(i));
    end
    skid_push_s = accept_s && hid_ok_s;
    skid_pop_s  = (skid_cnt_r != 2'd0) && (|(bus.dst_valid & bus.dst_ready));
    skid_wr_s   = skid_rd_r ^ skid_cnt_r[0];
  end

  // Memory side accepts while the skid has room; bad-ID beats bypass it
  always_comb begin
    bus.mem_rready = !fifo_empty_s && (!hid_ok_s || (skid_cnt_r != 2'd2));
    if (skid_cnt_r != 2'd0) begin
      bus.dst_valid = skid_dst_r[skid_rd_r];
      bus.dst_last  = skid_last_r[skid_rd_r];
    end else begin
      bus.dst_valid = '0;
      bus.dst_last  = 1'b0;
    end
    bus.dst_data = skid_data_r[skid_rd_r];
  end

  // Skid buffer storage, read pointer and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        skid_dst_r[i]  <= '0;
        skid_data_r[i] <= '0;
        skid_last_r[i] <= 1'b0;
      end
      skid_rd_r  <= 1'b0;
      skid_cnt_r <= 2'd0;
    end else begin
      if (skid_push_s) begin
        skid_dst_r[skid_wr_s]  <= head_onehot_s;
        skid_data_r[skid_wr_s] <= bus.mem_rdata;
        skid_last_r[skid_wr_s] <= at_last_s;
      end else begin
        skid_dst_r[skid_wr_s] <= skid_dst_r[skid_wr_s];
      end
      skid_rd_r <= skid_pop_s ? ~skid_rd_r : skid_rd_r;
      case ({skid_push_s, skid_pop_s})
        2'b10:   skid_cnt_r <= skid_cnt_r + 2'd1;
        2'b01:   skid_cnt_r <= skid_cnt_r - 2'd1;
        default: skid_cnt_r <= skid_cnt_r;
      endcase
    end
  end

`else

  // Zero-latency routing straight from the FIFO head
  always_comb begin
    bus.mem_rready = !fifo_empty_s && (!hid_ok_s || sel_ready_s);
    bus.dst_valid  = '0;
    for (int i = 0; i < N_DST; i++) begin
      bus.dst_valid[i] = bus.mem_rvalid && !fifo_empty_s && (head_s.id == MAX_ID_W'(i));
    end
    bus.dst_data = bus.mem_rdata;
    bus.dst_last = at_last_s;
  end

`endif

endmodule

// File: tb/tb_mem_resp_demux.sv
// Bench for mem_resp_demux (default pass-through build). The reference model
// expands every accepted request into a queue of expected beat slots
// {destination, last}; the head slot predicts routing for the current cycle.
module tb_mem_resp_demux;
  import mem_resp_pkg::*;

  localparam int WIDTH = 32;
  localparam int N_DST = 2;
  localparam int ID_W  = 2;
  localparam int LEN_W = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_resp_demux_if #(.WIDTH(WIDTH), .N_DST(N_DST), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  mem_resp_demux #(
    .WIDTH(WIDTH), .N_DST(N_DST), .ID_W(ID_W), .LEN_W(LEN_W), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int id;
    bit last;
  } slot_t;

  slot_t mq[$];
  bit    m_err = 1'b0;

  function automatic int m_bursts();
    int n = 0;
    foreach (mq[k]) if (mq[k].last) n++;
    return n;
  endfunction

  function automatic bit m_rready();
    if (mq.size() == 0) return 1'b0;
    if (mq[0].id >= N_DST) return 1'b1;
    return bus.dst_ready[mq[0].id];
  endfunction

  // model state update on each clock edge (reset clears everything)
  always @(posedge clk or posedge rst) begin
    int nb;
    if (rst) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      nb = m_bursts();
      if (bus.mem_rvalid && m_rready()) begin
        if (mq[0].id >= N_DST) m_err = 1'b1;
        void'(mq.pop_front());
      end
      if (bus.req_fire && nb < DEPTH) begin
        for (int k = 0; k <= int'(bus.req_len); k++)
          mq.push_back('{id: int'(bus.req_id), last: (k == int'(bus.req_len))});
      end
    end
  end

  // ---------------- per-cycle compare + receive log ----------------
  logic [31:0] rx0_d[$];
  bit          rx0_l[$];
  logic [31:0] rx1_d[$];
  bit          rx1_l[$];

  always @(negedge clk) begin
    logic [N_DST-1:0] ev;
    bit el;
    ev = '0;
    el = 1'b0;
    if (mq.size() != 0) begin
      el = mq[0].last;
      if (bus.mem_rvalid && mq[0].id < N_DST) ev[mq[0].id] = 1'b1;
    end
    check("req_ready",  bus.req_ready,  m_bursts() < DEPTH);
    check("mem_rready", bus.mem_rready, m_rready());
    check("dst_valid",  bus.dst_valid,  ev);
    check("dst_last",   bus.dst_last,   el);
    check("id_err",     bus.id_err,     m_err);
    if (ev != '0) check("dst_data", bus.dst_data, bus.mem_rdata);
    if (!rst) begin
      if (bus.dst_valid[DST_ICACHE] && bus.dst_ready[DST_ICACHE]) begin
        rx0_d.push_back(bus.dst_data);
        rx0_l.push_back(bus.dst_last);
      end
      if (bus.dst_valid[DST_DCACHE] && bus.dst_ready[DST_DCACHE]) begin
        rx1_d.push_back(bus.dst_data);
        rx1_l.push_back(bus.dst_last);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int id, input int len);
    bus.req_fire = 1'b1;
    bus.req_id   = ID_W'(id);
    bus.req_len  = LEN_W'(len);
  endtask

  task automatic clear_rx();
    rx0_d.delete(); rx0_l.delete(); rx1_d.delete(); rx1_l.delete();
  endtask

  logic [31:0] d3 [7] = '{32'h20, 32'h21, 32'h22, 32'h22, 32'h22, 32'h22, 32'h23};
  bit          r3 [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    bus.req_fire   = 1'b0;
    bus.req_id     = '0;
    bus.req_len    = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.dst_ready  = 2'b11;

    // reset state
    at_neg();
    check("rst_req_ready",  bus.req_ready,  1'b1);
    check("rst_mem_rready", bus.mem_rready, 1'b0);
    check("rst_dst_valid",  bus.dst_valid,  2'b00);
    check("rst_dst_last",   bus.dst_last,   1'b0);
    check("rst_id_err",     bus.id_err,     1'b0);
    step();
    rst = 1'b0;

    // single-beat burst; a response in the push cycle must stall
    push(1, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    at_neg();
    check("t1_push_cycle_rready", bus.mem_rready, 1'b0);
    check("t1_push_cycle_valid",  bus.dst_valid,  2'b00);
    step();
    bus.req_fire = 1'b0;
    at_neg();
    check("t1_valid", bus.dst_valid,  2'b10);
    check("t1_last",  bus.dst_last,   1'b1);
    check("t1_data",  bus.dst_data,   32'hDEADBEEF);
    check("t1_ready", bus.mem_rready, 1'b1);
    step();
    bus.mem_rvalid = 1'b0;
    at_neg();
    check("t1_empty_after", bus.mem_rready, 1'b0);

    // in-order bursts to icache then dcache
    clear_rx();
    step();
    push(0, 3);
    step();
    push(1, 1);
    step();
    bus.req_fire = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h10 + 32'(k);
      step();
    end
    bus.mem_rvalid = 1'b0;
    check("t2_ic_count", rx0_d.size(), 4);
    check("t2_dc_count", rx1_d.size(), 2);
    for (int k = 0; k < 4; k++) begin
      check("t2_ic_data", rx0_d[k], 32'h10 + 32'(k));
      check("t2_ic_last", rx0_l[k], (k == 3));
    end
    for (int k = 0; k < 2; k++) begin
      check("t2_dc_data", rx1_d[k], 32'h14 + 32'(k));
      check("t2_dc_last", rx1_l[k], (k == 1));
    end

    // backpressure from icache mid-burst
    clear_rx();
    push(0, 3);
    step();
    bus.req_fire = 1'b0;
    for (int c = 0; c < 7; c++) begin
      bus.mem_rvalid   = 1'b1;
      bus.mem_rdata    = d3[c];
      bus.dst_ready[0] = r3[c];
      at_neg();
      if (!r3[c]) check("t3_stall_rready", bus.mem_rready, 1'b0);
      step();
    end
    bus.mem_rvalid = 1'b0;
    bus.dst_ready  = 2'b11;
    check("t3_count", rx0_d.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("t3_data", rx0_d[k], 32'h20 + 32'(k));
      check("t3_last", rx0_l[k], (k == 3));
    end

    // fill the tracking FIFO
    for (int k = 0; k < 4; k++) begin
      push(0, 0);
      step();
    end
    bus.req_fire = 1'b0;
    at_neg();
    check("t4_full_req_ready", bus.req_ready, 1'b0);
    bus.mem_rvalid = 1'b1;
    step();
    bus.mem_rvalid = 1'b0;
    at_neg();
    check("t4_req_ready_after_pop", bus.req_ready, 1'b1);
    bus.mem_rvalid = 1'b1;
    repeat (3) step();
    bus.mem_rvalid = 1'b0;

    // out-of-range requester ID is drained and flagged
    push(3, 1);
    step();
    bus.req_fire   = 1'b0;
    bus.mem_rvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      check("t5_drain_rready", bus.mem_rready, 1'b1);
      check("t5_no_valid",     bus.dst_valid,  2'b00);
      step();
    end
    bus.mem_rvalid = 1'b0;
    at_neg();
    check("t5_id_err", bus.id_err, 1'b1);
    repeat (3) step();
    at_neg();
    check("t5_id_err_sticky", bus.id_err, 1'b1);

    // reset in the middle of a burst
    step();
    push(0, 3);
    step();
    bus.req_fire   = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h30;
    step();
    bus.mem_rdata  = 32'h31;
    step();
    bus.mem_rdata  = 32'h32;
    rst = 1'b1;
    #1;
    check("t6_rst_rready",    bus.mem_rready, 1'b0);
    check("t6_rst_valid",     bus.dst_valid,  2'b00);
    check("t6_rst_last",      bus.dst_last,   1'b0);
    check("t6_rst_req_ready", bus.req_ready,  1'b1);
    check("t6_rst_id_err",    bus.id_err,     1'b0);
    step();
    rst = 1'b0;
    at_neg();
    check("t6_stall_after_rst", bus.mem_rready, 1'b0);
    step();
    push(0, 0);
    bus.mem_rdata = 32'h40;
    step();
    bus.req_fire = 1'b0;
    at_neg();
    check("t6_new_valid", bus.dst_valid, 2'b01);
    check("t6_new_last",  bus.dst_last,  1'b1);
    check("t6_new_data",  bus.dst_data,  32'h40);
    step();
    bus.mem_rvalid = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.req_fire   = ($urandom_range(0, 2) == 0) && (m_bursts() < DEPTH);
      bus.req_id     = ($urandom_range(0, 15) == 0) ? ID_W'($urandom_range(2, 3))
                                                    : ID_W'($urandom_range(0, 1));
      bus.req_len    = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(0, 15))
                                                   : LEN_W'($urandom_range(0, 3));
      bus.mem_rvalid = ($urandom_range(0, 3) != 0);
      bus.mem_rdata  = $urandom;
      bus.dst_ready  = 2'($urandom_range(0, 3)) | (($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00);
      rst            = (c == 1500);
      step();
    end
    rst            = 1'b0;
    bus.req_fire   = 1'b0;
    bus.mem_rvalid = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_resp_demux.md
Name: mem_resp_demux

Overview:
- Return-path companion to the request-side source selector in the CPU/cache subsystem.
- The request arbiter picks one requester (icache/dcache/uncached) onto the shared memory port; this block routes each read-response burst back to the requester that issued it.
- Tracks outstanding requests in order in a small ID FIFO.
- Counts beats per burst and steers data to the matching destination with valid/ready handshakes.

Parameters:
- WIDTH, 32, response data width.
- N_DST, 2, number of destinations (0 = icache, 1 = dcache).
- ID_W, 1, width of the requester ID.
- LEN_W, 4, burst length field width; value = beats-1.
- DEPTH, 4, outstanding-request FIFO depth (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_fire  in  1  memory request accepted this cycle; push tracking entry.
- req_id  in  ID_W  source of the accepted request.
- req_len  in  LEN_W  beats-1 of the accepted request.
- req_ready  out  1  tracking FIFO not full; the arbiter must gate req_fire with it.
- mem_rvalid  in  1  response beat valid from memory.
- mem_rdata  in  WIDTH  response beat data.
- mem_rready  out  1  beat accepted.
- dst_valid  out  N_DST  one-hot valid to the destination.
- dst_data  out  WIDTH  data, shared by all destinations.
- dst_last  out  1  current beat is the last of its burst.
- dst_ready  in  N_DST  per-destination ready.
- id_err  out  1  sticky: a response was routed for an ID >= N_DST.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; beat_cnt = 0; id_err = 0.
  - req_ready = 1; mem_rready = 0; dst_valid = 0; dst_last = 0; dst_data = 0 in registered mode.
- Push:
  - On req_fire with FIFO not full, write {req_id, req_len} at the write pointer.
  - req_fire while full is a protocol violation: the entry is dropped and the simulation assertion fires.
  - req_ready = !full, registered-state based. A same-cycle pop does not free a slot for a same-cycle push.
- Routing (default mode, zero latency, combinational from FIFO head):
  - head = {hid, hlen}.
  - dst_valid[i] = mem_rvalid & !empty & (hid == i).
  - mem_rready = !empty & (hid >= N_DST ? 1 : dst_ready[hid]).
  - dst_last = !empty & (beat_cnt == hlen).
- Beat handshake = mem_rvalid & mem_rready:
  - Not the last beat: beat_cnt++.
  - Last beat: beat_cnt <= 0 and the FIFO pops.
- Empty FIFO: mem_rready = 0, so responses stall. A push in cycle N routes a response no earlier than cycle N+1.
- Out-of-range hid: beats are drained and discarded (no dst_valid); id_err is set on the first such beat and held until reset.
- Pointers are DEPTH-wrapping with an extra wrap bit for full/empty. Full = DEPTH entries outstanding.
- Simultaneous push and pop on a non-full FIFO: both take effect; count unchanged.
- Reset mid-burst clears all state. In-flight beats after reset stall until new requests are pushed.
- hlen = 0 means a single-beat burst: dst_last = 1 on the first beat.

Optional Feature:
- Macro: MEM_RESP_DEMUX_OUTREG_EN.
- Defined:
  - dst_valid, dst_data and dst_last come from a 2-entry skid buffer; latency is 1 cycle.
  - Full throughput (1 beat/cycle) while the destination is ready.
  - mem_rready = skid not full; beat_cnt and pop advance on mem acceptance.
  - Skid contents are cleared on reset.
- Undefined: the combinational pass-through described above.

Decomposition:
- Package mem_resp_pkg:
  - Destination ID constants (DST_ICACHE = 0, DST_DCACHE = 1).
  - Typedef resp_entry_t {id, len}.
  - Default WIDTH, LEN_W and DEPTH constants.
- Sub-module resp_id_fifo: generic synchronous FIFO with full/empty, parameterised width and depth. The demux instantiates it once.

Test Plan:
- Single beat: push id=1, len=0; next cycle rvalid, rdata=0xDEADBEEF → dst_valid=2'b10, dst_last=1; FIFO empty after the handshake.
- In-order bursts: push (0, len=3) then (1, len=1); 6 beats 0x10..0x15 → icache gets 0x10..0x13 with last on 0x13; dcache gets 0x14..0x15 with last on 0x15.
- Backpressure: dst_ready[0] low 3 cycles mid-burst → mem_rready=0 for those cycles, beat_cnt holds, no data lost or duplicated.
- Full: 4 pushes without responses → req_ready=0; a 5th req_fire triggers the assertion; after one burst completes, req_ready=1 the next cycle.
- Bad ID (ID_W=2, N_DST=2): push id=3, len=1 → 2 beats drained with mem_rready=1 and dst_valid=0; id_err=1 and stays 1.
- Reset mid-burst: assert rst after beat 2 of 4 → all outputs at reset values immediately; a new push (0, len=0) routes correctly with beat_cnt starting at 0.
